// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line widths plus the L2 arbiter's state and requester encodings.
package lc3b_types;

  localparam int unsigned LC3B_ADDR_W = 16;
  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } lc3b_arb_state;

  // Identifies a requester; used for last_grant and the transaction owner.
  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } lc3b_arb_src;

endpackage

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the unified L2 port between the L1 I-cache (read-only) and
// the L1 D-cache. One transaction at a time, round-robin on simultaneous requests.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_mem_address/read              I-cache miss request
//   i_mem_rdata/resp                I-cache line return and completion pulse
//   d_mem_address/read/write/wdata  D-cache miss or writeback request
//   d_mem_rdata/resp                D-cache line return and completion pulse
//   l2_address/wdata/read/write     latched request toward L2
//   l2_rdata/resp                   L2 line return and completion pulse
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = LC3B_ADDR_W,
  parameter int unsigned LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_mem_address,
  input  logic              i_mem_read,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  output logic              l2_read,
  output logic              l2_write,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  lc3b_arb_state     state_q, state_d;
  lc3b_arb_src       last_grant_q;
  lc3b_arb_src       grant_src;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              i_req;
  logic              d_req;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // Next-state and grant selection; requests are only looked at in IDLE.
  always_comb begin : next_state
    state_d   = state_q;
    grant     = 1'b0;
    grant_src = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          grant     = 1'b1;
          grant_src = (last_grant_q == ARB_I) ? ARB_D : ARB_I;
        end else if (i_req) begin
          grant     = 1'b1;
          grant_src = ARB_I;
        end else if (d_req) begin
          grant     = 1'b1;
          grant_src = ARB_D;
        end
        if (grant) begin
          state_d = (grant_src == ARB_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch; last_grant resets to D so I wins the first tie.
  always_ff @(posedge clk) begin : request_latch
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      last_grant_q <= ARB_D;
    end else if (grant) begin
      last_grant_q <= grant_src;
      if (grant_src == ARB_D) begin
        addr_q  <= d_mem_address;
        wdata_q <= d_mem_wdata;
        // A simultaneous read+write from D is treated as the write alone.
        write_q <= d_mem_write;
      end else begin
        addr_q  <= i_mem_address;
        write_q <= 1'b0;
      end
    end
  end

  // Output mux: strobes come from registered state/op; resp is routed to the owner only.
  always_comb begin : output_mux
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    i_mem_resp  = 1'b0;
    d_mem_resp  = 1'b0;
    l2_address  = addr_q;
    l2_wdata    = wdata_q;
    i_mem_rdata = l2_rdata;
    d_mem_rdata = l2_rdata;
    case (state_q)
      SERVE_I: begin
        l2_read    = ~write_q;
        l2_write   = write_q;
        i_mem_resp = l2_resp & ~rst;
      end
      SERVE_D: begin
        l2_read    = ~write_q;
        l2_write   = write_q;
        d_mem_resp = l2_resp & ~rst;
      end
      default: ;
    endcase
  end

endmodule
